// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage RV32 pipeline: EX forwarding selects, multi-cycle
// load-use stall and branch flush FSM. Define HAZARD_STATS_EN for stall/flush counters.
module pipeline_hazard_ctrl #(
   parameter int REG_ADDR_W   = 5,
   parameter int LOAD_LATENCY = 1,
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] if_id_rs1,
   input  logic [REG_ADDR_W-1:0] if_id_rs2,
   input  logic [REG_ADDR_W-1:0] id_ex_rs1,
   input  logic [REG_ADDR_W-1:0] id_ex_rs2,
   input  logic [REG_ADDR_W-1:0] id_ex_rd,
   input  logic                  id_ex_mem_read,
   input  logic [REG_ADDR_W-1:0] ex_mem_rd,
   input  logic [REG_ADDR_W-1:0] mem_wb_rd,
   input  logic                  ex_mem_reg_write,
   input  logic                  mem_wb_reg_write,
   input  logic                  branch_taken,
   output logic                  stall,
   output logic                  bubble_ex,
   output logic                  flush,
   output logic [1:0]            fwd_a,
   output logic [1:0]            fwd_b,
   output logic                  busy,
   output logic [31:0]           stall_cnt,
   output logic [31:0]           flush_cnt
);

   typedef enum logic [1:0] {ST_IDLE, ST_LU_WAIT, ST_FLUSH} state_t;

   localparam logic [CNT_W-1:0] LU_RELOAD = CNT_W'(LOAD_LATENCY - 1);
   localparam logic [CNT_W-1:0] FL_RELOAD = CNT_W'(FLUSH_CYCLES - 1);

   state_t             r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic               w_lu;

   always_comb begin
      fwd_a = 2'b00;
      if (ex_mem_reg_write && ex_mem_rd != '0 && ex_mem_rd == id_ex_rs1)
         fwd_a = 2'b10;
      else if (mem_wb_reg_write && mem_wb_rd != '0 && mem_wb_rd == id_ex_rs1)
         fwd_a = 2'b01;
   end

   always_comb begin
      fwd_b = 2'b00;
      if (ex_mem_reg_write && ex_mem_rd != '0 && ex_mem_rd == id_ex_rs2)
         fwd_b = 2'b10;
      else if (mem_wb_reg_write && mem_wb_rd != '0 && mem_wb_rd == id_ex_rs2)
         fwd_b = 2'b01;
   end

   assign w_lu = id_ex_mem_read && (id_ex_rd != '0) &&
                 ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // The detection cycle counts as the first stall/flush cycle, so the counter holds the remainder.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (branch_taken) begin
         if (FLUSH_CYCLES > 1) begin
            w_state_nxt = ST_FLUSH;
            w_cnt_nxt   = FL_RELOAD;
         end else begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (w_lu && LOAD_LATENCY > 1) begin
                  w_state_nxt = ST_LU_WAIT;
                  w_cnt_nxt   = LU_RELOAD;
               end
            end
            ST_LU_WAIT, ST_FLUSH: begin
               if (r_cnt <= CNT_W'(1)) begin
                  w_state_nxt = ST_IDLE;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt   = r_cnt - 1'b1;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   always_comb begin
      stall     = 1'b0;
      bubble_ex = 1'b0;
      flush     = 1'b0;
      if (branch_taken) begin
         flush = 1'b1;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               stall     = w_lu;
               bubble_ex = w_lu;
            end
            ST_LU_WAIT: begin
               stall     = 1'b1;
               bubble_ex = 1'b1;
            end
            ST_FLUSH: flush = 1'b1;
            default: ;
         endcase
      end
   end

   assign busy = (r_state != ST_IDLE);

`ifdef HAZARD_STATS_EN
   logic [31:0] r_stall_cnt, r_flush_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (stall && r_stall_cnt != '1)
            r_stall_cnt <= r_stall_cnt + 32'd1;
         if (flush && r_flush_cnt != '1)
            r_flush_cnt <= r_flush_cnt + 32'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: three instances share stimulus, each with
// different latency/flush parameters; expectations are queued per cycle and popped on check.
module tb_pipeline_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] if_id_rs1 = '0, if_id_rs2 = '0, id_ex_rs1 = '0, id_ex_rs2 = '0, id_ex_rd = '0;
   logic [4:0] ex_mem_rd = '0, mem_wb_rd = '0;
   logic       id_ex_mem_read = 1'b0, ex_mem_reg_write = 1'b0, mem_wb_reg_write = 1'b0;
   logic       branch_taken = 1'b0;

   logic        a_stall, a_bubble, a_flush, a_busy;
   logic        b_stall, b_bubble, b_flush, b_busy;
   logic        c_stall, c_bubble, c_flush, c_busy;
   logic [1:0]  a_fwd_a, a_fwd_b, b_fwd_a, b_fwd_b, c_fwd_a, c_fwd_b;
   logic [31:0] a_scnt, a_fcnt, b_scnt, b_fcnt, c_scnt, c_fcnt;

   int unsigned nvec = 0;
   int unsigned nerr = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.REG_ADDR_W(5), .LOAD_LATENCY(3), .FLUSH_CYCLES(2), .CNT_W(4)) dut_a (
      .clk(clk), .rst(rst), .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
      .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd),
      .id_ex_mem_read(id_ex_mem_read), .ex_mem_rd(ex_mem_rd), .mem_wb_rd(mem_wb_rd),
      .ex_mem_reg_write(ex_mem_reg_write), .mem_wb_reg_write(mem_wb_reg_write),
      .branch_taken(branch_taken), .stall(a_stall), .bubble_ex(a_bubble), .flush(a_flush),
      .fwd_a(a_fwd_a), .fwd_b(a_fwd_b), .busy(a_busy), .stall_cnt(a_scnt), .flush_cnt(a_fcnt));

   pipeline_hazard_ctrl #(.REG_ADDR_W(5), .LOAD_LATENCY(4), .FLUSH_CYCLES(2), .CNT_W(4)) dut_b (
      .clk(clk), .rst(rst), .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
      .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd),
      .id_ex_mem_read(id_ex_mem_read), .ex_mem_rd(ex_mem_rd), .mem_wb_rd(mem_wb_rd),
      .ex_mem_reg_write(ex_mem_reg_write), .mem_wb_reg_write(mem_wb_reg_write),
      .branch_taken(branch_taken), .stall(b_stall), .bubble_ex(b_bubble), .flush(b_flush),
      .fwd_a(b_fwd_a), .fwd_b(b_fwd_b), .busy(b_busy), .stall_cnt(b_scnt), .flush_cnt(b_fcnt));

   pipeline_hazard_ctrl #(.REG_ADDR_W(5), .LOAD_LATENCY(2), .FLUSH_CYCLES(1), .CNT_W(4)) dut_c (
      .clk(clk), .rst(rst), .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
      .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd),
      .id_ex_mem_read(id_ex_mem_read), .ex_mem_rd(ex_mem_rd), .mem_wb_rd(mem_wb_rd),
      .ex_mem_reg_write(ex_mem_reg_write), .mem_wb_reg_write(mem_wb_reg_write),
      .branch_taken(branch_taken), .stall(c_stall), .bubble_ex(c_bubble), .flush(c_flush),
      .fwd_a(c_fwd_a), .fwd_b(c_fwd_b), .busy(c_busy), .stall_cnt(c_scnt), .flush_cnt(c_fcnt));

   task automatic zero_inputs();
      if_id_rs1 = '0; if_id_rs2 = '0; id_ex_rs1 = '0; id_ex_rs2 = '0; id_ex_rd = '0;
      ex_mem_rd = '0; mem_wb_rd = '0; id_ex_mem_read = 1'b0;
      ex_mem_reg_write = 1'b0; mem_wb_reg_write = 1'b0; branch_taken = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      zero_inputs();
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Expected control word layout: {stall, bubble_ex, flush, busy} in bits [3:0].
   task automatic drive(input logic lu, input logic [4:0] rd, input logic br, input logic [31:0] exp);
      @(negedge clk);
      id_ex_mem_read = lu;
      id_ex_rd       = rd;
      if_id_rs1      = 5'd0;
      if_id_rs2      = 5'd7;
      branch_taken   = br;
      exp_q.push_back(exp);
   endtask

   task automatic test_reset();
      logic [31:0] g, e;
      @(negedge clk);
      rst = 1'b1;
      zero_inputs();
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      #2;
      g = {28'd0, a_stall, a_bubble, a_flush, a_busy}; e = exp_q.pop_front(); nvec++;
      if (g !== e) begin nerr++; $display("FAIL reset_ctl: got %b expected %b", g[3:0], e[3:0]); end
      g = {28'd0, a_fwd_a, a_fwd_b}; e = exp_q.pop_front(); nvec++;
      if (g !== e) begin nerr++; $display("FAIL reset_fwd: got %b expected %b", g[3:0], e[3:0]); end
      g = c_scnt | c_fcnt; e = exp_q.pop_front(); nvec++;
      if (g !== e) begin nerr++; $display("FAIL reset_stats: got %h expected %h", g, e); end
      ex_mem_reg_write = 1'b1; ex_mem_rd = 5'd3; id_ex_rs1 = 5'd3;
      exp_q.push_back(32'h8);
      #1;
      g = {28'd0, a_fwd_a, a_fwd_b}; e = exp_q.pop_front(); nvec++;
      if (g !== e) begin nerr++; $display("FAIL reset_fwd_live: got %b expected %b", g[3:0], e[3:0]); end
      @(negedge clk);
      rst = 1'b0;
      zero_inputs();
   endtask

   typedef struct packed {
      logic ew, ww;
      logic [4:0] er, wr, r1, r2;
      logic [3:0] exp;
   } fcase_t;

   task automatic test_forwarding();
      fcase_t tbl [7];
      logic [31:0] g, e;
      tbl[0] = '{1'b1, 1'b1, 5'd5, 5'd5, 5'd5, 5'd3, 4'b1000};
      tbl[1] = '{1'b0, 1'b1, 5'd5, 5'd5, 5'd5, 5'd3, 4'b0100};
      tbl[2] = '{1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 5'd0, 4'b0000};
      tbl[3] = '{1'b1, 1'b1, 5'd4, 5'd9, 5'd4, 5'd9, 4'b1001};
      tbl[4] = '{1'b0, 1'b0, 5'd4, 5'd9, 5'd4, 5'd9, 4'b0000};
      tbl[5] = '{1'b1, 1'b1, 5'd6, 5'd6, 5'd2, 5'd6, 4'b0010};
      tbl[6] = '{1'b1, 1'b0, 5'd6, 5'd6, 5'd6, 5'd6, 4'b1010};
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         ex_mem_reg_write = tbl[i].ew; mem_wb_reg_write = tbl[i].ww;
         ex_mem_rd = tbl[i].er; mem_wb_rd = tbl[i].wr;
         id_ex_rs1 = tbl[i].r1; id_ex_rs2 = tbl[i].r2;
         exp_q.push_back({28'd0, tbl[i].exp});
         #2;
         g = {28'd0, a_fwd_a, a_fwd_b}; e = exp_q.pop_front(); nvec++;
         if (g !== e) begin nerr++; $display("FAIL fwd case%0d: got %b expected %b", i, g[3:0], e[3:0]); end
      end
      zero_inputs();
   endtask

   task automatic test_load_use();
      logic [31:0] g, e;
      logic [3:0] ex [5];
      ex = '{4'b1100, 4'b1101, 4'b1101, 4'b0000, 4'b0000};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive(i == 0, 5'd7, 1'b0, {28'd0, ex[i]});
         #2;
         g = {28'd0, a_stall, a_bubble, a_flush, a_busy}; e = exp_q.pop_front(); nvec++;
         if (g !== e) begin nerr++; $display("FAIL load_use cyc%0d: got %b expected %b", i, g[3:0], e[3:0]); end
      end
      // lu held through the window must not re-arm it
      for (int i = 0; i < 5; i++) begin
         drive(i < 3, 5'd7, 1'b0, {28'd0, ex[i]});
         #2;
         g = {28'd0, a_stall, a_bubble, a_flush, a_busy}; e = exp_q.pop_front(); nvec++;
         if (g !== e) begin nerr++; $display("FAIL lu_held cyc%0d: got %b expected %b", i, g[3:0], e[3:0]); end
      end
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 5'd0, 1'b0, 32'h0);
         #2;
         g = {28'd0, a_stall, a_bubble, a_flush, a_busy}; e = exp_q.pop_front(); nvec++;
         if (g !== e) begin nerr++; $display("FAIL lu_rd0 cyc%0d: got %b expected %b", i, g[3:0], e[3:0]); end
      end
   endtask

   task automatic test_branch();
      logic [31:0] g, e;
      logic [3:0] ex [3];
      ex = '{4'b0010, 4'b0011, 4'b0000};
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 5'd7, i == 0, {28'd0, ex[i]});
         #2;
         g = {28'd0, a_stall, a_bubble, a_flush, a_busy}; e = exp_q.pop_front(); nvec++;
         if (g !== e) begin nerr++; $display("FAIL branch cyc%0d: got %b expected %b", i, g[3:0], e[3:0]); end
      end
      for (int i = 0; i < 3; i++) begin
         drive(i == 0, 5'd7, i == 0, {28'd0, ex[i]});
         #2;
         g = {28'd0, a_stall, a_bubble, a_flush, a_busy}; e = exp_q.pop_front(); nvec++;
         if (g !== e) begin nerr++; $display("FAIL branch_lu cyc%0d: got %b expected %b", i, g[3:0], e[3:0]); end
      end
   endtask

   task automatic test_mid_stall_branch();
      logic [31:0] g, e;
      logic [3:0] ex [6];
      ex = '{4'b1100, 4'b0011, 4'b0011, 4'b0000, 4'b0000, 4'b0000};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         drive(i == 0, 5'd7, i == 1, {28'd0, ex[i]});
         #2;
         g = {28'd0, b_stall, b_bubble, b_flush, b_busy}; e = exp_q.pop_front(); nvec++;
         if (g !== e) begin nerr++; $display("FAIL mid_stall cyc%0d: got %b expected %b", i, g[3:0], e[3:0]); end
      end
   endtask

   task automatic test_async_reset();
      logic [31:0] g, e;
      do_reset();
      drive(1'b1, 5'd7, 1'b0, 32'hC);
      #2;
      g = {28'd0, b_stall, b_bubble, b_flush, b_busy}; e = exp_q.pop_front(); nvec++;
      if (g !== e) begin nerr++; $display("FAIL arst_pre0: got %b expected %b", g[3:0], e[3:0]); end
      drive(1'b0, 5'd7, 1'b0, 32'hD);
      #2;
      g = {28'd0, b_stall, b_bubble, b_flush, b_busy}; e = exp_q.pop_front(); nvec++;
      if (g !== e) begin nerr++; $display("FAIL arst_pre1: got %b expected %b", g[3:0], e[3:0]); end
      #1 rst = 1'b1;
      exp_q.push_back(32'h0);
      #1;
      g = {28'd0, b_stall, b_bubble, b_flush, b_busy}; e = exp_q.pop_front(); nvec++;
      if (g !== e) begin nerr++; $display("FAIL arst_now: got %b expected %b", g[3:0], e[3:0]); end
      @(negedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 5'd7, 1'b0, 32'h0);
         #2;
         g = {28'd0, b_stall, b_bubble, b_flush, b_busy}; e = exp_q.pop_front(); nvec++;
         if (g !== e) begin nerr++; $display("FAIL arst_post cyc%0d: got %b expected %b", i, g[3:0], e[3:0]); end
      end
   endtask

   task automatic test_stats();
      logic [31:0] g, e;
      logic [3:0] ex [8];
      logic lu_seq [8];
      logic br_seq [8];
      ex     = '{4'b1100, 4'b1101, 4'b0000, 4'b1100, 4'b1101, 4'b0000, 4'b0010, 4'b0000};
      lu_seq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      br_seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      do_reset();
      for (int i = 0; i < 8; i++) begin
         drive(lu_seq[i], 5'd7, br_seq[i], {28'd0, ex[i]});
         #2;
         g = {28'd0, c_stall, c_bubble, c_flush, c_busy}; e = exp_q.pop_front(); nvec++;
         if (g !== e) begin nerr++; $display("FAIL stats_ctl cyc%0d: got %b expected %b", i, g[3:0], e[3:0]); end
      end
`ifdef HAZARD_STATS_EN
      exp_q.push_back(32'd4);
      exp_q.push_back(32'd1);
`else
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd0);
`endif
      g = c_scnt; e = exp_q.pop_front(); nvec++;
      if (g !== e) begin nerr++; $display("FAIL stall_cnt: got %0d expected %0d", g, e); end
      g = c_fcnt; e = exp_q.pop_front(); nvec++;
      if (g !== e) begin nerr++; $display("FAIL flush_cnt: got %0d expected %0d", g, e); end
   endtask

   initial begin
      test_reset();
      test_forwarding();
      test_load_use();
      test_branch();
      test_mid_stall_branch();
      test_async_reset();
      test_stats();
      if (exp_q.size() != 0) begin
         nerr++;
         $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
